bist_session_sequencer: RTL and testbench



---
 rtl/bist_pkg.sv | 21 ++
 rtl/bist_misr4.sv | 35 +++
 rtl/bist_session_sequencer.sv | 139 +++++++++++++
 tb/tb_bist_session_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and constants for the full-adder BIST session sequencer.
// Included by the sequencer top and its MISR sub-block.
package bist_pkg;

    localparam int PAT_W = 3;
    localparam int SIG_W = 4;

    // x^4 + x + 1: feedback from bit 3 lands on bits 0 and 1
    localparam logic [SIG_W-1:0] MISR_TAPS = 4'b0011;
    localparam logic [SIG_W-1:0] DEFAULT_GOLDEN_SIG = 4'hB;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        APPLY,
        CAPTURE,
        COMPARE,
        HOLD
    } state_t;

endpackage

// File: rtl/bist_misr4.sv
// 4-bit multiple-input signature register, 2-bit parallel input {cout,sum}.
// Load returns it to the seed; enable shifts in one response.
module bist_misr4
    import bist_pkg::*;
#(
    parameter logic [SIG_W-1:0] SEED = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [1:0]       din,
    output logic [SIG_W-1:0] q
);

    logic [SIG_W-1:0] r_q;
    logic [SIG_W-1:0] w_next;

    assign w_next = {r_q[SIG_W-2:0], 1'b0}
                  ^ ({SIG_W{r_q[SIG_W-1]}} & MISR_TAPS)
                  ^ {{(SIG_W-2){1'b0}}, din};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= SEED;
        end else if (load) begin
            r_q <= SEED;
        end else if (enable) begin
            r_q <= w_next;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/bist_session_sequencer.sv
// Runs one exhaustive self-test session on an external full adder and
// reports a MISR signature with pass/fail and a start/done handshake.
module bist_session_sequencer
    import bist_pkg::*;
#(
    parameter int               NUM_PATTERNS = 8,
    parameter logic [SIG_W-1:0] GOLDEN_SIG   = DEFAULT_GOLDEN_SIG,
    parameter logic [SIG_W-1:0] MISR_SEED    = 4'h0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             testmode,
    input  logic             start,
    input  logic [PAT_W-1:0] func_abc,
    output logic [PAT_W-1:0] cut_abc,
    input  logic             cut_sum,
    input  logic             cut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fault_detected,
    output logic [SIG_W-1:0] signature,
    output logic [PAT_W-1:0] pattern_idx
);

    localparam logic [PAT_W-1:0] LAST_IDX = PAT_W'(NUM_PATTERNS - 1);

    state_t           r_state;
    state_t           w_next;
    logic             w_init;
    logic             w_cap;
    logic             w_cmp;
    logic             w_last;
    logic [SIG_W-1:0] w_misr;

    logic [PAT_W-1:0] r_idx;
    logic [SIG_W-1:0] r_sig;
    logic             r_pass;
    logic             r_fault;
    logic             r_done;

    assign w_last = (r_idx == LAST_IDX);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // INIT clears results even when aborting, so an abort never leaves stale pass
    always_comb begin
        w_next = r_state;
        w_init = 1'b0;
        w_cap  = 1'b0;
        w_cmp  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (testmode && start) w_next = INIT;
            end
            INIT: begin
                w_init = 1'b1;
                w_next = testmode ? APPLY : IDLE;
            end
            APPLY: begin
                w_next = testmode ? CAPTURE : IDLE;
            end
            CAPTURE: begin
                if (!testmode) begin
                    w_next = IDLE;
                end else begin
                    w_cap  = 1'b1;
                    w_next = w_last ? COMPARE : APPLY;
                end
            end
            COMPARE: begin
                w_cmp  = 1'b1;
                w_next = HOLD;
            end
            HOLD: begin
                if (!testmode) begin
                    w_next = IDLE;
                end else if (start) begin
                    w_next = INIT;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    bist_misr4 #(
        .SEED(MISR_SEED)
    ) u_misr (
        .clock  (clock),
        .reset  (reset),
        .load   (w_init),
        .enable (w_cap),
        .din    ({cut_cout, cut_sum}),
        .q      (w_misr)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx   <= '0;
            r_sig   <= '0;
            r_pass  <= 1'b0;
            r_fault <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_cmp;
            if (w_init) begin
                r_idx   <= '0;
                r_pass  <= 1'b0;
                r_fault <= 1'b0;
            end
            if (w_cap && !w_last) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_cmp) begin
                r_sig   <= w_misr;
                r_pass  <= (w_misr == GOLDEN_SIG);
                r_fault <= (w_misr != GOLDEN_SIG);
            end
        end
    end

    assign busy = (r_state == INIT) || (r_state == APPLY)
               || (r_state == CAPTURE) || (r_state == COMPARE);

    assign cut_abc = (!testmode && r_state == IDLE) ? func_abc : r_idx;

    assign done           = r_done;
    assign pass           = r_pass;
    assign fault_detected = r_fault;
    assign signature      = r_sig;
    assign pattern_idx    = r_idx;

endmodule

// File: tb/tb_bist_session_sequencer.sv
// Self-checking bench for bist_session_sequencer with a behavioural adder
// and an exhaustive-pattern signature model.
module tb_bist_session_sequencer;

    localparam int NP = 8;

    logic       clock;
    logic       reset;
    logic       testmode;
    logic       start;
    logic [2:0] func_abc;
    logic [2:0] cut_abc;
    logic       cut_sum;
    logic       cut_cout;
    logic       busy;
    logic       done;
    logic       pass;
    logic       fault_detected;
    logic [3:0] signature;
    logic [2:0] pattern_idx;

    int n_checks = 0;
    int n_pass   = 0;
    int fault_kind = 0;

    bist_session_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .testmode       (testmode),
        .start          (start),
        .func_abc       (func_abc),
        .cut_abc        (cut_abc),
        .cut_sum        (cut_sum),
        .cut_cout       (cut_cout),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fault_detected (fault_detected),
        .signature      (signature),
        .pattern_idx    (pattern_idx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural adder; fault_kind 1/2 = sum s-a-0/1, 3/4 = cout s-a-0/1
    always_comb begin
        cut_sum  = cut_abc[2] ^ cut_abc[1] ^ cut_abc[0];
        cut_cout = (32'(cut_abc[2]) + 32'(cut_abc[1]) + 32'(cut_abc[0])) >= 2;
        case (fault_kind)
            1: cut_sum  = 1'b0;
            2: cut_sum  = 1'b1;
            3: cut_cout = 1'b0;
            4: cut_cout = 1'b1;
            default: ;
        endcase
    end

    function automatic logic [3:0] ref_sig(input int kind);
        logic [3:0] m;
        logic [2:0] v;
        logic       s;
        logic       co;
        m = 4'h0;
        for (int p = 0; p < NP; p++) begin
            v  = p[2:0];
            s  = v[2] ^ v[1] ^ v[0];
            co = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
            if (kind == 1) s = 1'b0;
            if (kind == 2) s = 1'b1;
            if (kind == 3) co = 1'b0;
            if (kind == 4) co = 1'b1;
            m = {m[2], m[1], m[0] ^ m[3] ^ co, m[3] ^ s};
        end
        return m;
    endfunction

    // Runs one session from IDLE/HOLD; noise != 0 pulses start while busy
    task automatic run_session(input bit noise, output int lat,
                               output int ndone, output int trace_err,
                               output logic busy1);
        int noise_c;
        noise_c   = $urandom_range(15, 2);
        lat       = -1;
        ndone     = 0;
        trace_err = 0;
        busy1     = 1'b0;
        @(negedge clock);
        testmode = 1'b1;
        start    = 1'b1;
        @(posedge clock);
        for (int c = 1; c <= 26; c++) begin
            @(negedge clock);
            if (c == 1) busy1 = busy;
            if (c >= 2 && c <= 2 * NP + 1) begin
                if (cut_abc !== 3'((c - 2) / 2)) trace_err++;
            end
            if (done === 1'b1) begin
                ndone++;
                if (lat < 0) lat = c - 1;
            end
            start = (noise && c == noise_c) ? 1'b1 : 1'b0;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        testmode = 1'b0;
        start    = 1'b0;
        func_abc = 3'b000;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if ({busy, done, pass, fault_detected, signature, pattern_idx}
            !== 10'b0)
            $display("FAIL reset_outputs got=%b want=0",
                     {busy, done, pass, fault_detected, signature,
                      pattern_idx});
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_functional();
        int bad;
        bad = 0;
        func_abc = 3'b101;
        @(negedge clock);
        n_checks++;
        if (cut_abc !== 3'b101)
            $display("FAIL func_101 got=%b want=101", cut_abc);
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            func_abc = 3'($urandom);
            start    = 1'($urandom);
            @(negedge clock);
            if (cut_abc !== func_abc || busy !== 1'b0 || done !== 1'b0)
                bad++;
        end
        start = 1'b0;
        n_checks++;
        if (bad !== 0)
            $display("FAIL func_random got=%0d bad want=0", bad);
        else n_pass++;
    endtask

    task automatic test_good_session();
        int lat, nd, terr;
        logic b1;
        fault_kind = 0;
        run_session(1'b0, lat, nd, terr, b1);
        n_checks++;
        if (b1 !== 1'b1) $display("FAIL good_busy got=%b want=1", b1);
        else n_pass++;
        n_checks++;
        if (terr !== 0) $display("FAIL good_trace got=%0d want=0", terr);
        else n_pass++;
        n_checks++;
        if (lat !== 2 * NP + 2 || nd !== 1)
            $display("FAIL good_done lat=%0d n=%0d want=%0d/1",
                     lat, nd, 2 * NP + 2);
        else n_pass++;
        n_checks++;
        if (signature !== 4'hB || signature !== ref_sig(0))
            $display("FAIL good_sig got=%h want=B", signature);
        else n_pass++;
        n_checks++;
        if (pass !== 1'b1 || fault_detected !== 1'b0)
            $display("FAIL good_flags got=%b%b want=10", pass,
                     fault_detected);
        else n_pass++;
        n_checks++;
        if (pattern_idx !== 3'(NP - 1) || busy !== 1'b0)
            $display("FAIL good_hold idx=%0d busy=%b want=%0d/0",
                     pattern_idx, busy, NP - 1);
        else n_pass++;
    endtask

    task automatic test_sum_stuck();
        int lat, nd, terr;
        logic b1;
        fault_kind = 1;
        run_session(1'b0, lat, nd, terr, b1);
        fault_kind = 0;
        n_checks++;
        if (signature !== 4'h8 || signature !== ref_sig(1))
            $display("FAIL sa0_sig got=%h want=8", signature);
        else n_pass++;
        n_checks++;
        if (pass !== 1'b0 || fault_detected !== 1'b1 || nd !== 1)
            $display("FAIL sa0_flags got=%b%b n=%0d want=01 n=1",
                     pass, fault_detected, nd);
        else n_pass++;
    endtask

    task automatic test_abort();
        int lat, nd, terr;
        logic b1;
        logic [3:0] sig_before;
        bit seen;
        int ndone;
        fault_kind = 0;
        run_session(1'b0, lat, nd, terr, b1);
        sig_before = signature;
        seen = 1'b0;
        @(negedge clock);
        start = 1'b1;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (pattern_idx === 3'd3 && busy === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) $display("FAIL abort_reach got=timeout want=idx3");
        else n_pass++;
        testmode = 1'b0;
        func_abc = 3'($urandom);
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0 || cut_abc !== func_abc)
            $display("FAIL abort_exit busy=%b abc=%b want=0/%b",
                     busy, cut_abc, func_abc);
        else n_pass++;
        n_checks++;
        if (pass !== 1'b0 || fault_detected !== 1'b0 ||
            signature !== sig_before)
            $display("FAIL abort_results got=%b%b %h want=00 %h", pass,
                     fault_detected, signature, sig_before);
        else n_pass++;
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clock);
            if (done === 1'b1) ndone++;
        end
        n_checks++;
        if (ndone !== 0) $display("FAIL abort_done got=%0d want=0", ndone);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat, nd, terr;
        logic b1;
        bit seen;
        seen = 1'b0;
        testmode = 1'b1;
        start    = 1'b1;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (pattern_idx === 3'd4) seen = 1'b1;
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (!seen || {busy, done, pass, fault_detected, signature,
                      pattern_idx} !== 10'b0)
            $display("FAIL reset_mid got=%b seen=%0d want=0",
                     {busy, done, pass, fault_detected, signature,
                      pattern_idx}, seen);
        else n_pass++;
        reset = 1'b0;
        run_session(1'b0, lat, nd, terr, b1);
        n_checks++;
        if (signature !== 4'hB || pass !== 1'b1)
            $display("FAIL reset_rerun got=%h/%b want=B/1", signature, pass);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat, nd, terr;
        logic b1;
        fault_kind = 0;
        for (int s = 0; s < 2; s++) begin
            run_session(1'b1, lat, nd, terr, b1);
            n_checks++;
            if (lat !== 2 * NP + 2 || nd !== 1 || terr !== 0)
                $display("FAIL b2b_%0d lat=%0d n=%0d terr=%0d want=%0d/1/0",
                         s, lat, nd, terr, 2 * NP + 2);
            else n_pass++;
            n_checks++;
            if (signature !== 4'hB)
                $display("FAIL b2b_sig_%0d got=%h want=B", s, signature);
            else n_pass++;
        end
    endtask

    task automatic test_random_faults();
        int lat, nd, terr;
        logic b1;
        logic [3:0] exp_sig;
        for (int s = 0; s < 5; s++) begin
            fault_kind = $urandom_range(4, 0);
            exp_sig = ref_sig(fault_kind);
            run_session(1'b1, lat, nd, terr, b1);
            n_checks++;
            if (signature !== exp_sig || nd !== 1 ||
                pass !== (exp_sig == 4'hB) ||
                fault_detected !== (exp_sig != 4'hB))
                $display("FAIL rand_fault_%0d got=%h %b%b n=%0d want=%h",
                         fault_kind, signature, pass, fault_detected, nd,
                         exp_sig);
            else n_pass++;
        end
        fault_kind = 0;
    endtask

    initial begin
        test_reset();
        test_functional();
        test_good_session();
        test_sum_stuck();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random_faults();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
